// File: rtl/seal_pkg.sv
// seal_pkg
// Shared definitions for the seal-record blocks (seal register and seal
// verifier): state encodings, status bit positions and the record layout
// constants. Ports: none (package only).
package seal_pkg;

    // Top-level verifier states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_CHECK = 2'd2
    } ver_state_e;

    // CRC feeder handshake states.
    typedef enum logic [1:0] {
        FD_IDLE  = 2'd0,
        FD_SEND  = 2'd1,
        FD_SKIP  = 2'd2,
        FD_DRAIN = 2'd3
    } feed_state_e;

    // Bytes pushed through the CRC engine per record:
    // sensor_id, value[7:0..31:24], mono[7:0..31:24].
    localparam int SEAL_NBYTES = 9;

    // Required content of word2[7:0].
    localparam logic [7:0] SEAL_PAD = 8'h00;

    // status_out bit positions.
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_PASS     = 2;
    localparam int STAT_CRC_ERR  = 3;
    localparam int STAT_MONO_ERR = 4;
    localparam int STAT_SID_ERR  = 5;
    localparam int STAT_FMT_ERR  = 6;
    localparam int STAT_DROPPED  = 7;

endpackage

// File: rtl/seal_crc_feeder.sv
// seal_crc_feeder
// Walks a SEAL_NBYTES message (byte 0 in msg[7:0]) into the shared CRC
// engine. For each byte it waits for the engine to be idle, presents the
// byte with a one-cycle feed pulse, then skips one cycle so the engine's
// busy flag has time to rise. After the last byte it waits for the engine
// to go idle and pulses done, at which point crc_value is final.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse, begins a new message (engine already inited)
//   msg         message bytes, byte 0 in the low bits
//   crc_busy    engine processing
//   crc_byte    byte presented to the engine (0 when not feeding)
//   crc_feed    one-cycle feed pulse
//   done        one-cycle pulse, last byte absorbed and engine idle
module seal_crc_feeder
    import seal_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [SEAL_NBYTES*8-1:0] msg,
    input  logic                     crc_busy,
    output logic [7:0]               crc_byte,
    output logic                     crc_feed,
    output logic                     done
);

    localparam logic [3:0] LAST_IDX = 4'(SEAL_NBYTES);

    feed_state_e state, state_next;
    logic [3:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FD_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            if (start)
                idx <= 4'd0;
            else if (crc_feed)
                idx <= idx + 4'd1;
        end
    end

    // idx counts bytes already fed, so after the final feed it equals
    // SEAL_NBYTES and the skip state hands over to the drain wait.
    always_comb begin
        state_next = state;
        crc_feed   = 1'b0;
        crc_byte   = 8'h00;
        done       = 1'b0;
        case (state)
            FD_IDLE: begin
                if (start)
                    state_next = FD_SEND;
            end
            FD_SEND: begin
                if (!crc_busy) begin
                    crc_feed   = 1'b1;
                    crc_byte   = msg[{idx, 3'b000} +: 8];
                    state_next = FD_SKIP;
                end
            end
            FD_SKIP: begin
                state_next = (idx == LAST_IDX) ? FD_DRAIN : FD_SEND;
            end
            FD_DRAIN: begin
                if (!crc_busy) begin
                    done       = 1'b1;
                    state_next = FD_IDLE;
                end
            end
            default: state_next = FD_IDLE;
        endcase
    end

endmodule

// File: rtl/seal_verifier.sv
// seal_verifier
// Consumer end of the seal-record format. Software writes the three record
// words and then a start command carrying the expected sensor_id. The block
// recomputes CRC16 over sensor_id, value and mono_count on the shared
// engine, checks pad, CRC, session id and strict monotonic ordering, and
// reports a verdict plus saturating pass/fail counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   crc_byte/feed/init    drive the shared CRC engine
//   crc_busy, crc_value   engine status and result
//   rec_wr, rec_in        record word write (IDLE only)
//   ctrl_wr, ctrl_in      {sensor_id[7:0], start, clear}
//   status_out            verdict and statistics
//   rec_idx               next record-word index
module seal_verifier
    import seal_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  crc_byte,
    output logic        crc_feed,
    output logic        crc_init,
    input  logic        crc_busy,
    input  logic [15:0] crc_value,
    input  logic        rec_wr,
    input  logic [31:0] rec_in,
    input  logic        ctrl_wr,
    input  logic [9:0]  ctrl_in,
    output logic [31:0] status_out,
    output logic [1:0]  rec_idx
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ver_state_e       state, state_next;
    logic [31:0]      word0, word1, word2;
    logic [7:0]       sensor_id, locked_sid;
    logic [31:0]      last_mono;
    logic             have_last, session_locked, start_dropped;
    logic             done, pass, crc_err, mono_err, sid_err, fmt_err;
    logic [CNT_W-1:0] pass_count, fail_count;
    logic             start_go, feed_done;
    logic [31:0]      mono;
    logic [7:0]       rec_sid;
    logic             chk_fmt, chk_crc, chk_mono, chk_sid, chk_pass;

    assign mono    = {word2[31:24], word1[23:0]};
    assign rec_sid = word1[31:24];

    // A start is only honoured in IDLE; the engine init goes out in the
    // same cycle so it lands before the feeder's first byte.
    assign start_go = ctrl_wr && ctrl_in[1] && (state == ST_IDLE);
    assign crc_init = start_go;

    assign chk_fmt  = word2[7:0] != SEAL_PAD;
    assign chk_crc  = crc_value != word2[23:8];
    assign chk_mono = have_last && (mono <= last_mono);
    assign chk_sid  = session_locked && (rec_sid != locked_sid);
    assign chk_pass = !(chk_fmt || chk_crc || chk_mono || chk_sid);

    seal_crc_feeder u_feeder (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_go),
        .msg      ({mono, word0, sensor_id}),
        .crc_busy (crc_busy),
        .crc_byte (crc_byte),
        .crc_feed (crc_feed),
        .done     (feed_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_go)  state_next = ST_FEED;
            ST_FEED:  if (feed_done) state_next = ST_CHECK;
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Record capture, commands, and the verdict/history update in CHECK.
    // A failing record leaves ordering and session state untouched so a
    // forged record cannot move the monotonic floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word0          <= '0;
            word1          <= '0;
            word2          <= '0;
            rec_idx        <= 2'd0;
            sensor_id      <= 8'h00;
            locked_sid     <= 8'h00;
            last_mono      <= '0;
            have_last      <= 1'b0;
            session_locked <= 1'b0;
            start_dropped  <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            crc_err        <= 1'b0;
            mono_err       <= 1'b0;
            sid_err        <= 1'b0;
            fmt_err        <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
        end else if (state == ST_IDLE) begin
            if (rec_wr) begin
                case (rec_idx)
                    2'd0:    word0 <= rec_in;
                    2'd1:    word1 <= rec_in;
                    default: word2 <= rec_in;
                endcase
                rec_idx <= (rec_idx == 2'd2) ? 2'd0 : rec_idx + 2'd1;
            end
            if (ctrl_wr && ctrl_in[1]) begin
                sensor_id <= ctrl_in[9:2];
                rec_idx   <= 2'd0;
                done      <= 1'b0;
                pass      <= 1'b0;
                crc_err   <= 1'b0;
                mono_err  <= 1'b0;
                sid_err   <= 1'b0;
                fmt_err   <= 1'b0;
            end else if (ctrl_wr && ctrl_in[0]) begin
                done           <= 1'b0;
                pass           <= 1'b0;
                crc_err        <= 1'b0;
                mono_err       <= 1'b0;
                sid_err        <= 1'b0;
                fmt_err        <= 1'b0;
                pass_count     <= '0;
                fail_count     <= '0;
                have_last      <= 1'b0;
                session_locked <= 1'b0;
                start_dropped  <= 1'b0;
            end
        end else begin
            if (ctrl_wr && ctrl_in[1])
                start_dropped <= 1'b1;
            if (state == ST_CHECK) begin
                done     <= 1'b1;
                pass     <= chk_pass;
                crc_err  <= chk_crc;
                mono_err <= chk_mono;
                sid_err  <= chk_sid;
                fmt_err  <= chk_fmt;
                if (chk_pass) begin
                    last_mono <= mono;
                    have_last <= 1'b1;
                    if (!session_locked) begin
                        session_locked <= 1'b1;
                        locked_sid     <= rec_sid;
                    end
                    if (pass_count != CNT_MAX)
                        pass_count <= pass_count + 1'b1;
                end else if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_out                = '0;
        status_out[STAT_BUSY]     = state != ST_IDLE;
        status_out[STAT_DONE]     = done;
        status_out[STAT_PASS]     = pass;
        status_out[STAT_CRC_ERR]  = crc_err;
        status_out[STAT_MONO_ERR] = mono_err;
        status_out[STAT_SID_ERR]  = sid_err;
        status_out[STAT_FMT_ERR]  = fmt_err;
        status_out[STAT_DROPPED]  = start_dropped;
        status_out[15:8]          = 8'(pass_count);
        status_out[23:16]         = 8'(fail_count);
    end

endmodule

// File: tb/tb_seal_verifier.sv
// tb_seal_verifier
// Drives seal_verifier against a behavioural CRC16-CCITT engine with a
// randomised busy latency, and predicts every verdict from the record rules
// (pad, CRC, session id, strict ordering, saturating counters).
module tb_seal_verifier;

    logic        clk;
    logic        rst_n;
    logic [7:0]  crc_byte;
    logic        crc_feed;
    logic        crc_init;
    logic        crc_busy;
    logic [15:0] crc_value;
    logic        rec_wr;
    logic [31:0] rec_in;
    logic        ctrl_wr;
    logic [9:0]  ctrl_in;
    logic [31:0] status_out;
    logic [1:0]  rec_idx;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the verifier's history and statistics.
    logic [31:0] m_last_mono;
    bit          m_have_last;
    bit          m_locked;
    logic [7:0]  m_lsid;
    logic [7:0]  m_pass_cnt;
    logic [7:0]  m_fail_cnt;
    bit          m_dropped;

    logic [7:0]  feed_log[$];

    seal_verifier #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .crc_byte   (crc_byte),
        .crc_feed   (crc_feed),
        .crc_init   (crc_init),
        .crc_busy   (crc_busy),
        .crc_value  (crc_value),
        .rec_wr     (rec_wr),
        .rec_in     (rec_in),
        .ctrl_wr    (ctrl_wr),
        .ctrl_in    (ctrl_in),
        .status_out (status_out),
        .rec_idx    (rec_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] crcUpd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] sealCrc(input logic [7:0] sid, input logic [31:0] v,
                                            input logic [31:0] m);
        logic [15:0] c;
        c = crcUpd(16'hFFFF, sid);
        for (int i = 0; i < 4; i++) c = crcUpd(c, v[8*i +: 8]);
        for (int i = 0; i < 4; i++) c = crcUpd(c, m[8*i +: 8]);
        return c;
    endfunction

    // Behavioural shared CRC engine: busy for 1..3 cycles after each feed.
    logic [15:0] eng_crc;
    logic        eng_busy;
    int          eng_cnt;
    logic [7:0]  eng_pend;

    assign crc_busy  = eng_busy;
    assign crc_value = eng_crc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_crc  <= 16'hFFFF;
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            eng_pend <= 8'h00;
        end else if (crc_init) begin
            eng_crc <= 16'hFFFF;
        end else if (crc_feed) begin
            eng_busy <= 1'b1;
            eng_cnt  <= int'($urandom_range(1, 3));
            eng_pend <= crc_byte;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_busy <= 1'b0;
                eng_crc  <= crcUpd(eng_crc, eng_pend);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (crc_feed)
            feed_log.push_back(crc_byte);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_last_mono = 32'h0;
        m_have_last = 1'b0;
        m_locked    = 1'b0;
        m_lsid      = 8'h00;
        m_pass_cnt  = 8'h00;
        m_fail_cnt  = 8'h00;
        m_dropped   = 1'b0;
    endtask

    task automatic writeWord(input logic [31:0] w);
        @(negedge clk);
        rec_wr = 1'b1;
        rec_in = w;
        @(negedge clk);
        rec_wr = 1'b0;
        rec_in = 32'h0;
    endtask

    task automatic pulseCtrl(input logic [9:0] c);
        @(negedge clk);
        ctrl_wr = 1'b1;
        ctrl_in = c;
        @(negedge clk);
        ctrl_wr = 1'b0;
        ctrl_in = 10'h0;
    endtask

    task automatic clearAll();
        pulseCtrl({8'h00, 2'b01});
        m_pass_cnt  = 8'h00;
        m_fail_cnt  = 8'h00;
        m_have_last = 1'b0;
        m_locked    = 1'b0;
        m_dropped   = 1'b0;
        checkOutput("status_after_clear", status_out, 32'h0);
    endtask

    task automatic loadRecord(input logic [7:0] rec_sid, input logic [31:0] value,
                              input logic [31:0] mono, input logic [15:0] crc_xor,
                              input logic [7:0] pad);
        logic [15:0] field;
        field = sealCrc(rec_sid, value, mono) ^ crc_xor;
        writeWord(value);
        checkOutput("rec_idx_after_w0", 32'(rec_idx), 32'd1);
        writeWord({rec_sid, mono[23:0]});
        writeWord({mono[31:24], field, pad});
        checkOutput("rec_idx_wrap", 32'(rec_idx), 32'd0);
    endtask

    // One full verify: load, start, optionally poke a start and a record
    // write mid-feed, wait for done, then compare verdict and fed bytes.
    task automatic applyStimulus(input logic [7:0] exp_sid, input logic [7:0] rec_sid,
                                 input logic [31:0] value, input logic [31:0] mono,
                                 input logic [15:0] crc_xor, input logic [7:0] pad,
                                 input bit disturb);
        int          base;
        int          guard;
        logic [71:0] got, want;
        bit          fe, ce, me, se, ok;
        logic [31:0] exp_stat;

        loadRecord(rec_sid, value, mono, crc_xor, pad);
        base = feed_log.size();
        pulseCtrl({exp_sid, 2'b10});
        checkOutput("busy_after_start", 32'(status_out[1:0]), 32'd1);

        if (disturb) begin
            guard = 0;
            while ((feed_log.size() - base) < 2 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            ctrl_wr = 1'b1;
            ctrl_in = {exp_sid, 2'b10};
            rec_wr  = 1'b1;
            rec_in  = 32'hDEAD_BEEF;
            @(negedge clk);
            ctrl_wr = 1'b0;
            ctrl_in = 10'h0;
            rec_wr  = 1'b0;
            rec_in  = 32'h0;
            m_dropped = 1'b1;
            checkOutput("rec_idx_ignored_when_busy", 32'(rec_idx), 32'd0);
        end

        guard = 0;
        while (!status_out[1] && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_in_time", 32'(status_out[1]), 32'd1);

        fe = (pad != 8'h00);
        ce = (sealCrc(exp_sid, value, mono) != (sealCrc(rec_sid, value, mono) ^ crc_xor));
        me = m_have_last && (mono <= m_last_mono);
        se = m_locked && (rec_sid != m_lsid);
        ok = !(fe || ce || me || se);
        if (ok) begin
            m_last_mono = mono;
            m_have_last = 1'b1;
            if (!m_locked) begin
                m_locked = 1'b1;
                m_lsid   = rec_sid;
            end
            if (m_pass_cnt != 8'hFF) m_pass_cnt++;
        end else if (m_fail_cnt != 8'hFF) begin
            m_fail_cnt++;
        end
        exp_stat = {8'h00, m_fail_cnt, m_pass_cnt, m_dropped, fe, se, me, ce, ok, 1'b1, 1'b0};
        checkOutput("status_verdict", status_out, exp_stat);

        checkOutput("feed_count", 32'(feed_log.size() - base), 32'd9);
        got = '0;
        for (int i = 0; i < 9; i++)
            if (base + i < feed_log.size())
                got[8*i +: 8] = feed_log[base + i];
        want = {mono, value, exp_sid};
        checkOutput("feed_bytes_lo", got[31:0], want[31:0]);
        checkOutput("feed_bytes_hi", {got[71:64], got[55:32]}, {want[71:64], want[55:32]});
        checkOutput("feed_bytes_mid", 32'(got[63:56]), 32'(want[63:56]));
    endtask

    initial begin
        int          base;
        int          guard;
        logic [7:0]  rs, es;
        logic [31:0] mo;
        logic [15:0] cx;
        logic [7:0]  pd;

        rst_n   = 1'b0;
        rec_wr  = 1'b0;
        rec_in  = 32'h0;
        ctrl_wr = 1'b0;
        ctrl_in = 10'h0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_status", status_out, 32'h0);
        checkOutput("reset_rec_idx", 32'(rec_idx), 32'd0);
        checkOutput("reset_feed_outputs", {22'h0, crc_feed, crc_init, crc_byte}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic pass and CRC corruption");
        applyStimulus(8'h05, 8'h05, 32'h1234_5678, 32'h0, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'h1234_5678, 32'h0, 16'h0001, 8'h00, 1'b0);

        $display("[TB] replay, rollback and wrap");
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0001, 32'd5, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0002, 32'd5, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0003, 32'd4, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0004, 32'd6, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0005, 32'hFFFF_FFFF, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h05, 32'hA5A5_0006, 32'h0, 16'h0, 8'h00, 1'b0);

        $display("[TB] session lock");
        clearAll();
        applyStimulus(8'h3A, 8'h3A, 32'h0BAD_F00D, 32'd1, 16'h0, 8'h00, 1'b0);
        applyStimulus(8'h3B, 8'h3B, 32'h0BAD_F00E, 32'd2, 16'h0, 8'h00, 1'b0);
        clearAll();
        applyStimulus(8'h3B, 8'h3B, 32'h0BAD_F00F, 32'd3, 16'h0, 8'h00, 1'b0);

        $display("[TB] format error and dropped start");
        applyStimulus(8'h3B, 8'h3B, 32'h1111_2222, 32'd4, 16'h0, 8'h01, 1'b0);
        applyStimulus(8'h3B, 8'h3B, 32'h3333_4444, 32'd5, 16'h0, 8'h00, 1'b1);

        $display("[TB] reset during feed");
        loadRecord(8'h3B, 32'h5555_6666, 32'd6, 16'h0, 8'h00);
        base = feed_log.size();
        pulseCtrl({8'h3B, 2'b10});
        guard = 0;
        while ((feed_log.size() - base) < 4 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midrun_reset_status", status_out, 32'h0);
        checkOutput("midrun_reset_rec_idx", 32'(rec_idx), 32'd0);
        checkOutput("midrun_reset_feed", 32'(crc_feed), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = feed_log.size();
        repeat (30) @(negedge clk);
        checkOutput("no_feed_after_reset", 32'(feed_log.size() - base), 32'd0);
        applyStimulus(8'h3B, 8'h3B, 32'h5555_6666, 32'd6, 16'h0, 8'h00, 1'b0);

        $display("[TB] randomised records");
        for (int n = 0; n < 14; n++) begin
            rs = ($urandom_range(0, 3) == 0 || !m_locked) ? 8'($urandom) : m_lsid;
            es = ($urandom_range(0, 5) == 0) ? 8'($urandom) : rs;
            case ($urandom_range(0, 3))
                0:       mo = m_last_mono;
                1:       mo = m_last_mono + 32'($urandom_range(1, 100));
                2:       mo = $urandom;
                default: mo = m_last_mono + 32'd1;
            endcase
            cx = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
            pd = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            applyStimulus(es, rs, $urandom, mo, cx, pd, 1'b0);
        end

        $display("[TB] pass counter saturation");
        clearAll();
        for (int n = 0; n < 257; n++)
            applyStimulus(8'h42, 8'h42, $urandom, 32'(n + 1), 16'h0, 8'h00, 1'b0);
        checkOutput("pass_count_saturated", 32'(status_out[15:8]), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
